// File: rtl/tinyqv_qspi_target.sv
// -----------------------------------------------------------------------------
// tinyqv_qspi_target
//   QSPI flash-style target that bridges a host's quad-SPI transactions onto a
//   simple byte-wide backing store. Supports quad fast read (0xEB) with mode
//   byte and 4 dummy nibbles, and quad page program (0x38). All other commands
//   are ignored until the host deselects.
//
//   Build option: QSPI_TARGET_CONTINUOUS_READ_EN
//     When defined, a mode byte of 0xA0 arms continuous-read: the following
//     transaction skips the command phase and starts directly with the
//     address, behaving as 0xEB. Any other mode byte disarms it.
//     When undefined, the mode byte is ignored.
//
// Ports
//   clk           system clock, at least 4x spi_clk_in
//   rstn          asynchronous active-low reset
//   spi_clk_in    QSPI clock from host (oversampled)
//   spi_select    chip select from host, active-low
//   spi_data_in   QSPI data from host, D0 carries the serial command
//   spi_data_out  QSPI data to host, updated on falling spi clock edges
//   spi_data_oe   per-line output enable, 4'hF only while reading
//   mem_addr      backing-store byte address
//   mem_read      one-clk read strobe, data expected the following clk
//   mem_rdata     read data from backing store
//   mem_write     one-clk write strobe
//   mem_wdata     write byte, valid with mem_write
// -----------------------------------------------------------------------------
module tinyqv_qspi_target (
    input  logic        clk,
    input  logic        rstn,
    input  logic        spi_clk_in,
    input  logic        spi_select,
    input  logic [3:0]  spi_data_in,
    output logic [3:0]  spi_data_out,
    output logic [3:0]  spi_data_oe,
    output logic [23:0] mem_addr,
    output logic        mem_read,
    input  logic [7:0]  mem_rdata,
    output logic        mem_write,
    output logic [7:0]  mem_wdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_MODE,
        S_DUMMY,
        S_READ,
        S_WRITE,
        S_IGNORE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and spi clock edge detection
    // ------------------------------------------------------------------
    logic [1:0] sclk_sync;
    logic [1:0] sel_sync;
    logic [3:0] data_meta;
    logic [3:0] data_sync;
    logic       sclk_prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_sync <= 2'b00;
            sel_sync  <= 2'b11;     // deselected
            data_meta <= 4'h0;
            data_sync <= 4'h0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_clk_in};
            sel_sync  <= {sel_sync[0], spi_select};
            data_meta <= spi_data_in;
            data_sync <= data_meta;
            sclk_prev <= sclk_sync[1];
        end
    end

    logic sclk;
    logic deselected;
    logic rise;
    logic fall;

    // Clock and data share the same synchroniser depth, so data sampled on a
    // detected rise keeps the setup the host gave it.
    assign sclk       = sclk_sync[1];
    assign deselected = sel_sync[1];
    assign rise       = sclk & ~sclk_prev;
    assign fall       = ~sclk & sclk_prev;

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    state_t      state;
    logic [2:0]  cnt;          // edges seen within the current phase
    logic [6:0]  cmd_sh;       // first 7 command bits
    logic [19:0] addr_sh;      // first 5 address nibbles
    logic        is_write;     // 0x38 transaction
    logic        half;         // 0: high nibble next, 1: low nibble next
    logic [3:0]  nib_hi;       // held high nibble (mode or write data)
    logic [7:0]  next_byte;    // byte fetched for the next read
    logic [3:0]  lo_hold;      // low nibble of the byte being sent
`ifdef QSPI_TARGET_CONTINUOUS_READ_EN
    logic        cont;         // continuous-read armed by mode 0xA0
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            cnt          <= 3'd0;
            cmd_sh       <= 7'd0;
            addr_sh      <= 20'd0;
            is_write     <= 1'b0;
            half         <= 1'b0;
            nib_hi       <= 4'h0;
            next_byte    <= 8'h00;
            lo_hold      <= 4'h0;
            spi_data_out <= 4'h0;
            spi_data_oe  <= 4'h0;
            mem_addr     <= 24'd0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_wdata    <= 8'h00;
`ifdef QSPI_TARGET_CONTINUOUS_READ_EN
            cont         <= 1'b0;
`endif
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;

            // Read data arrives the clk after the strobe.
            if (mem_read)
                next_byte <= mem_rdata;

            // The write strobe carries the current address; advance afterwards.
            // Natural 24-bit overflow gives the 0xFFFFFF -> 0 wrap.
            if (mem_write)
                mem_addr <= mem_addr + 24'd1;

            if (deselected) begin
                // Any partially assembled write byte is simply dropped here.
                state        <= S_IDLE;
                spi_data_oe  <= 4'h0;
                spi_data_out <= 4'h0;
                cnt          <= 3'd0;
                half         <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        cnt  <= 3'd0;
                        half <= 1'b0;
`ifdef QSPI_TARGET_CONTINUOUS_READ_EN
                        if (cont) begin
                            is_write <= 1'b0;
                            state    <= S_ADDR;
                        end else begin
                            state    <= S_CMD;
                        end
`else
                        state <= S_CMD;
`endif
                    end

                    S_CMD: if (rise) begin
                        cmd_sh <= {cmd_sh[5:0], data_sync[0]};
                        cnt    <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            cnt <= 3'd0;
                            case ({cmd_sh, data_sync[0]})
                                8'hEB: begin
                                    is_write <= 1'b0;
                                    state    <= S_ADDR;
                                end
                                8'h38: begin
                                    is_write <= 1'b1;
                                    state    <= S_ADDR;
                                end
                                default: state <= S_IGNORE;
                            endcase
                        end
                    end

                    S_ADDR: if (rise) begin
                        addr_sh <= {addr_sh[15:0], data_sync};
                        cnt     <= cnt + 3'd1;
                        if (cnt == 3'd5) begin
                            cnt      <= 3'd0;
                            mem_addr <= {addr_sh, data_sync};
                            if (is_write) begin
                                half  <= 1'b0;
                                state <= S_WRITE;
                            end else begin
                                // Fetch the first byte now so it is ready
                                // long before the first read nibble.
                                mem_read <= 1'b1;
                                state    <= S_MODE;
                            end
                        end
                    end

                    S_MODE: if (rise) begin
                        nib_hi <= data_sync;
                        cnt    <= cnt + 3'd1;
                        if (cnt == 3'd1) begin
                            cnt   <= 3'd0;
                            state <= S_DUMMY;
`ifdef QSPI_TARGET_CONTINUOUS_READ_EN
                            cont  <= ({nib_hi, data_sync} == 8'hA0);
`endif
                        end
                    end

                    S_DUMMY: if (rise) begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd3) begin
                            cnt         <= 3'd0;
                            half        <= 1'b0;
                            spi_data_oe <= 4'hF;
                            state       <= S_READ;
                        end
                    end

                    S_READ: if (fall) begin
                        if (!half) begin
                            // Keep the low nibble aside: next_byte is about
                            // to be overwritten by the prefetch.
                            spi_data_out <= next_byte[7:4];
                            lo_hold      <= next_byte[3:0];
                            mem_addr     <= mem_addr + 24'd1;
                            mem_read     <= 1'b1;
                            half         <= 1'b1;
                        end else begin
                            spi_data_out <= lo_hold;
                            half         <= 1'b0;
                        end
                    end

                    S_WRITE: if (rise) begin
                        if (!half) begin
                            nib_hi <= data_sync;
                            half   <= 1'b1;
                        end else begin
                            mem_wdata <= {nib_hi, data_sync};
                            mem_write <= 1'b1;
                            half      <= 1'b0;
                        end
                    end

                    S_IGNORE: spi_data_oe <= 4'h0;

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tinyqv_qspi_target.sv
// -----------------------------------------------------------------------------
// tb_tinyqv_qspi_target
//   Drives QSPI transactions as a host would, serves the backing-store port
//   from an associative memory, and checks through a scoreboard: each issued
//   transaction pushes the nibbles or writes it should produce, and monitor
//   processes pop and compare whenever the DUT presents them. Expected data
//   comes from a byte-addressed reference memory updated at transaction level.
// -----------------------------------------------------------------------------
module tb_tinyqv_qspi_target;

    localparam int HALF = 50;  // spi half period, 5 system clocks

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        spi_clk_in = 1'b0;
    logic        spi_select = 1'b1;
    logic [3:0]  spi_data_in = 4'h0;
    logic [7:0]  mem_rdata = 8'h00;
    logic [3:0]  spi_data_out;
    logic [3:0]  spi_data_oe;
    logic [23:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_wdata;

    always #5 clk = ~clk;

    tinyqv_qspi_target dut (
        .clk          (clk),
        .rstn         (rstn),
        .spi_clk_in   (spi_clk_in),
        .spi_select   (spi_select),
        .spi_data_in  (spi_data_in),
        .spi_data_out (spi_data_out),
        .spi_data_oe  (spi_data_oe),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_rdata    (mem_rdata),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata)
    );

    int checks = 0;
    int passed = 0;

    logic [7:0]  store   [int];   // backing store seen by the DUT
    logic [7:0]  ref_mem [int];   // reference model contents
    logic [3:0]  nib_q [$];       // expected read nibbles
    logic [31:0] wr_q  [$];       // expected writes {addr, data}
    bit          rd_active = 1'b0;
    int          strobes = 0;
    int          oe_hits = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] ref_rd(input logic [23:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return 8'h00;
    endfunction

    function automatic logic [7:0] store_rd(input logic [23:0] a);
        if (store.exists(int'(a))) return store[int'(a)];
        return 8'h00;
    endfunction

    // Backing store, write monitor and activity counters.
    always @(negedge clk) begin
        if (mem_read) mem_rdata = store_rd(mem_addr);
        if (mem_write) begin
            store[int'(mem_addr)] = mem_wdata;
            if (wr_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got addr %h data %h, none expected", mem_addr, mem_wdata);
            end else begin
                check("mem_write", {mem_addr, mem_wdata}, wr_q.pop_front());
            end
        end
        if (mem_read || mem_write) strobes++;
        if (spi_data_oe != 4'h0) oe_hits++;
    end

    // Read nibble monitor: the host samples on its rising clock edge.
    always @(posedge spi_clk_in) begin
        if (rd_active) begin
            if (nib_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_nibble: got %h, none expected", spi_data_out);
            end else begin
                check("read_nibble", {24'd0, spi_data_oe, spi_data_out}, {24'd0, 4'hF, nib_q.pop_front()});
            end
        end
    end

    // ---------------- host side ----------------
    task automatic cyc(input logic [3:0] d);
        spi_data_in = d;
        #HALF spi_clk_in = 1'b1;
        #HALF spi_clk_in = 1'b0;
    endtask

    task automatic start_txn;
        @(negedge clk);
        spi_select = 1'b0;
        #(2*HALF);
    endtask

    task automatic end_txn;
        #HALF spi_select = 1'b1;
        #30;
        check("deselect_oe", {28'd0, spi_data_oe}, 32'd0);
        #(3*HALF);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        logic [2:0] junk;
        for (int i = 7; i >= 0; i--) begin
            junk = 3'($urandom());
            cyc({junk, c[i]});
        end
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) cyc(a[i*4 +: 4]);
    endtask

    task automatic read_txn(input logic [23:0] a, input int nbytes, input logic [7:0] mode, input bit with_cmd);
        logic [7:0]  b;
        logic [23:0] ai;
        start_txn();
        if (with_cmd) send_cmd(8'hEB);
        send_addr(a);
        cyc(mode[7:4]);
        cyc(mode[3:0]);
        repeat (4) cyc(4'($urandom()));
        for (int i = 0; i < nbytes; i++) begin
            ai = a + 24'(i);
            b = ref_rd(ai);
            nib_q.push_back(b[7:4]);
            nib_q.push_back(b[3:0]);
        end
        rd_active = 1'b1;
        repeat (2*nbytes) cyc(4'h0);
        rd_active = 1'b0;
        end_txn();
    endtask

    // bytes taken MSB first from data
    task automatic write_txn(input logic [23:0] a, input logic [31:0] data, input int nbytes);
        logic [7:0]  b;
        logic [23:0] ai;
        start_txn();
        send_cmd(8'h38);
        send_addr(a);
        for (int i = 0; i < nbytes; i++) begin
            b  = data[31-8*i -: 8];
            ai = a + 24'(i);
            ref_mem[int'(ai)] = b;
            wr_q.push_back({ai, b});
            cyc(b[7:4]);
            cyc(b[3:0]);
        end
        end_txn();
    endtask

    initial begin
        int s0, o0;
        logic [23:0] a;
        logic [7:0]  mode;
        int n;

        for (int i = 0; i < 4; i++) begin
            store[32'h100 + i]   = 8'h11 * (i + 1);
            ref_mem[32'h100 + i] = 8'h11 * (i + 1);
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data_out", {28'd0, spi_data_out}, 32'd0);
        check("rst_oe", {28'd0, spi_data_oe}, 32'd0);
        check("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_mem_addr", {8'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // Quad read of the preloaded bytes
        read_txn(24'h000100, 4, 8'h00, 1'b1);

        // Two-byte write, then a write across the top of the address space
        write_txn(24'h000010, 32'hABCD0000, 2);
        write_txn(24'hFFFFFF, 32'h5AA50000, 2);

        // Unsupported command with quad activity: nothing must happen
        s0 = strobes; o0 = oe_hits;
        start_txn();
        send_cmd(8'h03);
        repeat (16) cyc(4'($urandom()));
        end_txn();
        check("ignore_strobes", 32'(strobes - s0), 32'd0);
        check("ignore_oe", 32'(oe_hits - o0), 32'd0);
        read_txn(24'h000100, 2, 8'h00, 1'b1);

        // Deselect after one write nibble: byte dropped
        s0 = strobes;
        start_txn();
        send_cmd(8'h38);
        send_addr(24'h000020);
        cyc(4'h7);
        end_txn();
        check("partial_write_strobes", 32'(strobes - s0), 32'd0);
        write_txn(24'h000020, 32'h3C000000, 1);

        // Continuous read: armed by mode 0xA0, second transaction has no command
        read_txn(24'h000100, 2, 8'hA0, 1'b1);
`ifdef QSPI_TARGET_CONTINUOUS_READ_EN
        read_txn(24'h000102, 2, 8'h00, 1'b0);
`else
        s0 = strobes; o0 = oe_hits;
        start_txn();
        send_addr(24'h000102);
        cyc(4'h0); cyc(4'h0);
        repeat (4) cyc(4'($urandom()));
        repeat (4) cyc(4'h0);
        end_txn();
        check("nocont_strobes", 32'(strobes - s0), 32'd0);
        check("nocont_oe", 32'(oe_hits - o0), 32'd0);
`endif

        // Reset in the middle of a write, just before the completing nibble lands
        s0 = strobes;
        start_txn();
        send_cmd(8'h38);
        send_addr(24'h000040);
        cyc(4'h9);
        spi_data_in = 4'h6;
        #HALF spi_clk_in = 1'b1;
        #10 rstn = 1'b0;
        #20;
        check("midrst_mem_addr", {8'd0, mem_addr}, 32'd0);
        check("midrst_oe", {28'd0, spi_data_oe}, 32'd0);
        spi_clk_in = 1'b0;
        spi_select = 1'b1;
        #100 rstn = 1'b1;
        #100;
        check("midrst_strobes", 32'(strobes - s0), 32'd0);

        // Randomized write/read-back pairs
        for (int it = 0; it < 8; it++) begin
            a = (it % 3 == 0) ? 24'hFFFFFE : 24'($urandom_range(32'h200, 32'hFFFFFF));
            n = $urandom_range(1, 4);
            write_txn(a, $urandom(), n);
            mode = 8'($urandom());
            if (mode == 8'hA0) mode = 8'h00;
            read_txn(a, n, mode, 1'b1);
        end

        check("nibble_queue_empty", nib_q.size(), 32'd0);
        check("write_queue_empty", wr_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
